// File: rtl/uart_cmd_pkg.sv
// Shared receiver state type and command byte constants for the UART command controller.
// Defining UART_CMD_PARITY_EN adds the PARITY state (8E1 framing).
package uart_cmd_pkg;

`ifdef UART_CMD_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

    localparam logic [7:0] CMD_RUN       = 8'h72;  // 'r'
    localparam logic [7:0] CMD_CLR       = 8'h63;  // 'c'
    localparam logic [7:0] CMD_MODE      = 8'h6D;  // 'm'
    localparam logic [7:0] CMD_RUN_ALL   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_CLR_ALL   = 8'h43;  // 'C'
    localparam logic [7:0] CMD_MODE_ALL  = 8'h4D;  // 'M'
    localparam logic [7:0] CH_DIGIT_BASE = 8'h30;  // '0'

endpackage

// File: rtl/uart_cmd_rx.sv
// UART receiver: 2-FF rx synchroniser, free-running sample-tick divider and framing FSM.
// With UART_CMD_PARITY_EN defined an even-parity bit is expected after the data bits.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    rx_state_e        state_q;
    logic [OS_W-1:0]  cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q, ferr_q;
    logic             stop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LAST);

`ifdef UART_CMD_PARITY_EN
    logic perr_q;
    assign stop_ok = rx_sync_q && !perr_q;
`else
    assign stop_ok = rx_sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_sync_q) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        // Mid-start-bit recheck rejects short glitches.
                        if (cnt_q == HALF_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= rx_sync_q ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_sync_q, shift_q[7:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef UART_CMD_PARITY_EN
                    PARITY: begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q   <= '0;
                            perr_q  <= ^{shift_q, rx_sync_q};
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt_q == OS_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            if (stop_ok) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller top: receiver plus single-byte command decoder driving per-channel
// enable/clear/mode. UART_CMD_PARITY_EN (see uart_cmd_rx) selects 8E1 instead of 8N1.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int NUM_CH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [NUM_CH-1:0] o_enable,
    output logic [NUM_CH-1:0] o_clear,
    output logic [NUM_CH-1:0] o_mode,
    output logic [7:0]        o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] enable_q, clear_q, mode_q;
    logic [NUM_CH-1:0] sel_mask;

    uart_cmd_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err)
    );

    assign sel_mask = NUM_CH'(1) << sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            enable_q <= '0;
            clear_q  <= '0;
            mode_q   <= '0;
        end else begin
            clear_q <= '0;
            if (o_rx_valid) begin
                case (o_rx_data)
                    CMD_RUN:      enable_q <= enable_q ^ sel_mask;
                    CMD_CLR:      clear_q  <= sel_mask;
                    CMD_MODE:     mode_q   <= mode_q ^ sel_mask;
                    CMD_RUN_ALL:  enable_q <= ~enable_q;
                    CMD_CLR_ALL:  clear_q  <= '1;
                    CMD_MODE_ALL: mode_q   <= ~mode_q;
                    default: begin
                        // Digits beyond the channel count leave the selection alone.
                        if (o_rx_data >= CH_DIGIT_BASE && o_rx_data < CH_DIGIT_BASE + 8'(NUM_CH))
                            sel_q <= SEL_W'(o_rx_data - CH_DIGIT_BASE);
                    end
                endcase
            end
        end
    end

    assign o_enable = enable_q;
    assign o_clear  = clear_q;
    assign o_mode   = mode_q;

endmodule
